v2f_pow_seq: RTL and testbench

//  Multi-cycle implementation of the v2f_pow cell, which is produced when yosys
//  $pow is mapped to v2f cells. Computes Y = A ** B by iterative

---
 rtl/v2f_pkg.sv | 27 ++
 rtl/v2f_pow_seq_if.sv | 27 ++
 rtl/v2f_mul32_lo.sv | 13 +
 rtl/v2f_pow_seq.sv | 122 ++++++++++++
 tb/tb_v2f_pow_seq.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v2f_pkg.sv
// Shared definitions for the multi-cycle v2f arithmetic cells.
// Word width, FSM state encoding and the negative-exponent result decode.
package v2f_pkg;

    localparam int V2F_WORD_W = 32;

    typedef logic [V2F_WORD_W-1:0] v2f_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pow_state_t;

    // Integer result of base ** (negative exponent). Only +/-1 have an integral
    // reciprocal; everything else, including division by zero, resolves to 0.
    function automatic v2f_word_t neg_exp_result(input v2f_word_t base, input logic exp_odd);
        if (base == V2F_WORD_W'(1)) begin
            return V2F_WORD_W'(1);
        end
        if (base == '1) begin
            return exp_odd ? '1 : V2F_WORD_W'(1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/v2f_pow_seq_if.sv
// Operand/result handshake bundle of the sequential power unit.
// The master drives operands and consumes the result; the slave is the unit.
interface v2f_pow_seq_if #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32
);
    import v2f_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    v2f_word_t          y;
    logic               y_valid;
    logic               out_ready;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, y, y_valid
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, y, y_valid
    );

endinterface

// File: rtl/v2f_mul32_lo.sv
// Combinational 32x32 multiplier returning the low 32 product bits,
// which are identical for signed and unsigned operands.
module v2f_mul32_lo
    import v2f_pkg::*;
(
    input  v2f_word_t a_i,
    input  v2f_word_t b_i,
    output v2f_word_t p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/v2f_pow_seq.sv
// Sequential Y = A ** B by square-and-multiply, one exponent bit per cycle,
// with a valid/ready handshake on both operand and result sides.
module v2f_pow_seq
    import v2f_pkg::*;
#(
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 0,
    parameter int A_WIDTH  = 32,
    parameter int B_WIDTH  = 32
) (
    input logic            CLK,
    input logic            ARST,
    v2f_pow_seq_if.slave   io
);

    pow_state_t state_q, state_d;
    v2f_word_t  base_q, base_d;
    v2f_word_t  exp_q, exp_d;
    v2f_word_t  acc_q, acc_d;
    v2f_word_t  y_q, y_d;

    v2f_word_t  a_ext;
    v2f_word_t  b_ext;
    logic       b_neg;
    v2f_word_t  acc_mul;
    v2f_word_t  base_sq;
    v2f_word_t  exp_sh;

    generate
        if (A_SIGNED != 0) begin : g_a_sext
            assign a_ext = V2F_WORD_W'($signed(io.a));
        end else begin : g_a_zext
            assign a_ext = V2F_WORD_W'(io.a);
        end
    endgenerate

    // A non-negative exponent zero-extends the same way in both modes.
    assign b_ext  = V2F_WORD_W'(io.b);
    assign b_neg  = (B_SIGNED != 0) && io.b[B_WIDTH-1];
    assign exp_sh = exp_q >> 1;

    v2f_mul32_lo u_mul_acc (
        .a_i (acc_q),
        .b_i (base_q),
        .p_o (acc_mul)
    );

    v2f_mul32_lo u_mul_sq (
        .a_i (base_q),
        .b_i (base_q),
        .p_o (base_sq)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    base_d  = a_ext;
                    state_d = RUN;
                    // Negative exponents finish at accept; B==0 falls out as exp=0, acc=1.
                    if (b_neg) begin
                        exp_d = '0;
                        acc_d = neg_exp_result(a_ext, io.b[0]);
                    end else begin
                        exp_d = b_ext;
                        acc_d = V2F_WORD_W'(1);
                    end
                end
            end
            RUN: begin
                if (exp_q == '0) begin
                    y_d     = acc_q;
                    state_d = DONE;
                end else begin
                    if (exp_q[0]) begin
                        acc_d = acc_mul;
                    end
                    base_d = base_sq;
                    exp_d  = exp_sh;
                    if (exp_sh == '0) begin
                        y_d     = acc_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= IDLE;
            base_q  <= '0;
            exp_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    assign io.in_ready = (state_q == IDLE);
    assign io.y_valid  = (state_q == DONE);
    assign io.y        = y_q;

endmodule

// File: tb/tb_v2f_pow_seq.sv
// Scoreboarded bench for v2f_pow_seq: an unsigned 32/32 unit and a signed 8/6 unit,
// directed cases plus randomized operations against an arithmetic power model.
module tb_v2f_pow_seq;
    import v2f_pkg::*;

    typedef struct {
        logic [31:0] y;
        int          n;
    } exp_t;

    logic        CLK = 1'b0;
    logic        ARST;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m_y;
    logic        m_v;
    logic        m_r;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   acc_q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    v2f_pow_seq_if #(.A_WIDTH(32), .B_WIDTH(32)) ifu ();
    v2f_pow_seq_if #(.A_WIDTH(8),  .B_WIDTH(6))  ifs ();

    v2f_pow_seq #(.A_SIGNED(0), .B_SIGNED(0), .A_WIDTH(32), .B_WIDTH(32)) dut_u (
        .CLK (CLK), .ARST (ARST), .io (ifu)
    );
    v2f_pow_seq #(.A_SIGNED(1), .B_SIGNED(1), .A_WIDTH(8), .B_WIDTH(6)) dut_s (
        .CLK (CLK), .ARST (ARST), .io (ifs)
    );

    assign ifu.in_valid  = in_valid & ~sel;
    assign ifu.a         = a;
    assign ifu.b         = b;
    assign ifu.out_ready = out_ready;
    assign ifs.in_valid  = in_valid & sel;
    assign ifs.a         = a[7:0];
    assign ifs.b         = b[5:0];
    assign ifs.out_ready = out_ready;

    assign m_y = sel ? ifs.y       : ifu.y;
    assign m_v = sel ? ifs.y_valid : ifu.y_valid;
    assign m_r = sel ? ifs.in_ready : ifu.in_ready;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // x ** e mod 2^32: direct repeated multiplication for short exponents,
    // binary decomposition of e otherwise.
    function automatic logic [31:0] ipow(input logic [31:0] x, input logic [31:0] e);
        logic [31:0] r = 32'd1;
        logic [31:0] p = x;
        if (e < 32'd64) begin
            for (int i = 0; i < int'(e); i++) r = r * x;
            return r;
        end
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = r * p;
            p = p * p;
        end
        return r;
    endfunction

    function automatic int bitlen_lat(input logic [31:0] e);
        if (e == 32'd0) return 1;
        return $clog2(64'(e) + 64'd1);
    endfunction

    task automatic model(input logic [31:0] ta, input logic [31:0] tb_, output logic [31:0] ey, output int en);
        logic signed [31:0] xs;
        logic [5:0]         b6;
        if (!sel) begin
            ey = ipow(ta, tb_);
            en = bitlen_lat(tb_);
        end else begin
            xs = 32'(signed'(ta[7:0]));
            b6 = tb_[5:0];
            if (b6[5]) begin
                en = 1;
                if (xs == 1)       ey = 32'd1;
                else if (xs == -1) ey = b6[0] ? 32'hFFFF_FFFF : 32'd1;
                else               ey = 32'd0;
            end else begin
                ey = ipow(xs, {26'd0, b6});
                en = bitlen_lat({26'd0, b6});
            end
        end
    endtask

    // Call just after a rising edge; returns just after the accept edge.
    task automatic issue_exp(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] ey,
                             input int en, input bit hold, output int edge_o);
        exp_t e;
        int   k = 0;
        e.y = ey;
        e.n = en;
        exp_q.push_back(e);
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        while (!m_r && k < 200) begin
            @(posedge CLK); #1;
            k++;
        end
        if (!m_r) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", k);
        end
        @(posedge CLK); #1;
        edge_o = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input bit hold,
                         output int edge_o, output int n_o);
        logic [31:0] ey;
        model(ta, tb_, ey, n_o);
        issue_exp(ta, tb_, ey, n_o, hold, edge_o);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || !m_r) && k < 300) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic rand_operands(output logic [31:0] ta, output logic [31:0] tb_);
        case ($urandom_range(0, 4))
            0:       ta = 32'd0;
            1:       ta = 32'd1;
            2:       ta = 32'hFFFF_FFFF;
            3:       ta = 32'd2 + 32'($urandom_range(0, 5));
            default: ta = $urandom;
        endcase
        case ($urandom_range(0, 3))
            0:       tb_ = 32'd0;
            1:       tb_ = 32'($urandom_range(1, 40));
            default: tb_ = $urandom >> $urandom_range(0, 31);
        endcase
    endtask

    // Scoreboard monitor: records accepts, checks latency on Y_VALID rise,
    // Y stability under back-pressure and the value at each result handshake.
    initial begin
        exp_t e;
        logic [31:0] held_y = '0;
        bit prev_v = 1'b0;
        forever begin
            @(negedge CLK);
            if (ARST) begin
                prev_v = 1'b0;
            end else begin
                if (in_valid && m_r) acc_q.push_back(cyc + 1);
                if (m_v) begin
                    if (!prev_v) begin
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_valid: got y=%h with no pending op, expected none", m_y);
                        end else begin
                            chk_int("latency", cyc - acc_q.pop_front(), exp_q[0].n);
                        end
                        held_y = m_y;
                    end else if (!out_ready) begin
                        chk32("y_hold", m_y, held_y);
                    end
                    if (out_ready && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk32("result", m_y, e.y);
                    end
                end
                prev_v = m_v;
            end
        end
    end

    initial begin
        int edge_c, n_c, prev_edge, prev_n;
        logic [31:0] ra, rb;

        ARST      = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #1;
        chk32("rst_y_u", ifu.y, 32'd0);
        chk32("rst_yv_u", 32'(ifu.y_valid), 32'd0);
        chk32("rst_ir_u", 32'(ifu.in_ready), 32'd1);
        chk32("rst_y_s", ifs.y, 32'd0);
        chk32("rst_yv_s", 32'(ifs.y_valid), 32'd0);
        chk32("rst_ir_s", 32'(ifs.in_ready), 32'd1);
        @(posedge CLK); @(posedge CLK); #1;
        ARST = 1'b0;

        // Directed unsigned cases with literal expectations.
        issue_exp(32'd3, 32'd5,  32'h0000_00F3, 3, 1'b0, edge_c);
        drain();
        issue_exp(32'd2, 32'd31, 32'h8000_0000, 5, 1'b0, edge_c);
        drain();
        issue_exp(32'd3, 32'd21, 32'd1870418611, 5, 1'b0, edge_c);
        drain();

        // Signed special cases (6-bit B: 0x3D=-3, 0x3C=-4, 0x3E=-2).
        sel = 1'b1;
        issue_exp(32'hFF, 32'h3D, 32'hFFFF_FFFF, 1, 1'b0, edge_c);
        drain();
        issue_exp(32'hFF, 32'h3C, 32'd1, 1, 1'b0, edge_c);
        drain();
        issue_exp(32'd5,  32'h3E, 32'd0, 1, 1'b0, edge_c);
        drain();
        issue_exp(32'd7,  32'h00, 32'd1, 1, 1'b0, edge_c);
        drain();
        issue_exp(32'hFE, 32'd3,  32'hFFFF_FFF8, 2, 1'b0, edge_c);
        drain();
        sel = 1'b0;

        // Back-pressure: DONE held ten cycles while a new operation is offered.
        out_ready = 1'b0;
        issue_exp(32'd3, 32'd5, 32'h0000_00F3, 3, 1'b0, edge_c);
        begin
            int k = 0;
            while (!m_v && k < 100) begin
                @(posedge CLK); #1;
                k++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'd2;
            b        = 32'd3;
            chk32("bp_valid", 32'(m_v), 32'd1);
            chk32("bp_ready", 32'(m_r), 32'd0);
            chk32("bp_y", m_y, 32'h0000_00F3);
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (5) @(posedge CLK);
        #1;
        chk32("bp_ignored", 32'(m_v), 32'd0);

        // Asynchronous reset in the middle of a long run.
        issue_exp(32'd3, 32'h0000_FFFF, ipow(32'd3, 32'h0000_FFFF), 16, 1'b0, edge_c);
        repeat (3) @(posedge CLK);
        #1;
        ARST = 1'b1;
        #1;
        chk32("arst_y", m_y, 32'd0);
        chk32("arst_yv", 32'(m_v), 32'd0);
        chk32("arst_ir", 32'(m_r), 32'd1);
        exp_q.delete();
        acc_q.delete();
        @(posedge CLK); #1;
        ARST = 1'b0;
        chk32("rel_yv", 32'(m_v), 32'd0);
        chk32("rel_ir", 32'(m_r), 32'd1);
        issue_exp(32'd3, 32'd5, 32'h0000_00F3, 3, 1'b0, edge_c);
        drain();

        // Back-to-back with IN_VALID held: accepts spaced N+2 edges apart.
        prev_edge = -1;
        prev_n    = 0;
        for (int i = 0; i < 20; i++) begin
            rand_operands(ra, rb);
            issue(ra, rb, 1'b1, edge_c, n_c);
            if (prev_edge >= 0) chk_int("b2b_spacing", edge_c - prev_edge, prev_n + 2);
            prev_edge = edge_c;
            prev_n    = n_c;
        end
        in_valid = 1'b0;
        drain();

        // Randomized operations on both units.
        for (int i = 0; i < 700; i++) begin
            rand_operands(ra, rb);
            issue(ra, rb, ($urandom_range(0, 1) == 1), edge_c, n_c);
            if (i % 50 == 49) begin
                in_valid = 1'b0;
                drain();
            end
        end
        in_valid = 1'b0;
        drain();
        sel = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue($urandom, $urandom, ($urandom_range(0, 1) == 1), edge_c, n_c);
        end
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
